adder_carry_serial_seq: RTL and testbench
=========================================

Name: adder_carry_serial_seq

Overview:
Bit-serial sequencer that time-multiplexes one adder_carry slice (P/G/CI -> SUMOUT/CO, where SUMOUT = P^CI and CO = P ? CI : G) to perform WIDTH-bit add or subtract.
- Accepts an operand pair over a valid/ready handshake.
- Drives the slice one bit per cycle, LSB first, and registers the slice carry-out as the next carry-in.
- Returns sum, carry-out and signed overflow over a second valid/ready handshake.
- Sits in the CLB test/demo fabric as the controller for a single physical carry slice.

Parameters:
WIDTH, 8, operand and result width in bits (minimum 2).

Ports:
clk  input  1  fabric clock; all state updates on rising edge
reset  input  1  asynchronous, active-high reset
op_valid  input  1  operand pair offered
op_ready  output  1  sequencer can accept an operand pair
op_a  input  WIDTH  operand A
op_b  input  WIDTH  operand B
op_sub  input  1  0 = A+B, 1 = A-B
res_valid  output  1  result available
res_ready  input  1  consumer accepts the result
res_sum  output  WIDTH  sum or difference
res_cout  output  1  carry out of the MSB (for subtract: 1 = no borrow)
res_ovf  output  1  signed overflow
slice_p  output  1  to the adder_carry P input
slice_g  output  1  to the adder_carry G input
slice_cin  output  1  to the adder_carry CI input
slice_sumout  input  1  from the adder_carry SUMOUT output
slice_cout  input  1  from the adder_carry CO output

Behaviour:
- States: IDLE, RUN, DONE. Reset -> IDLE, asynchronously.
- Reset values: op_ready=1, res_valid=0, res_sum=0, res_cout=0, res_ovf=0, slice_p/g/cin=0. Bit counter, shift registers and carry register are cleared.
- IDLE:
  - op_ready=1.
  - On op_valid: load sa=op_a, sb=(op_sub ? ~op_b : op_b), carry=op_sub, cnt=0, then go to RUN.
- RUN:
  - op_ready=0.
  - slice_p = sa[0]^sb[0], slice_g = sa[0], slice_cin = carry. These are combinational from registers.
  - Each cycle:
    - Shift slice_sumout into the MSB of the result shift register (right shift).
    - Shift sa and sb right by 1.
    - carry <= slice_cout.
    - cnt <= cnt+1.
  - On the cycle cnt==WIDTH-1, capture the MSB carry-in (the current carry) as cin_msb, then go to DONE.
- DONE:
  - res_valid=1; res_sum = result register; res_cout = carry; res_ovf = carry ^ cin_msb.
  - Outputs are held stable while res_valid && !res_ready.
  - On res_ready, go to IDLE; res_valid drops the next cycle.
- Slice outputs are 0 in IDLE and DONE.
- Latency: operand accepted at edge T, res_valid high after edge T+WIDTH. One op per WIDTH+2 cycles with an always-ready consumer.
- op_valid in RUN/DONE is ignored (op_ready=0). Operands are not sampled after acceptance.
- Reset asserted mid-RUN or mid-DONE: the operation is abandoned and no result is emitted.
- Wrap-around: the sum is modulo 2^WIDTH, and the carry beyond the MSB appears only on res_cout.
- cnt width: $clog2(WIDTH), saturating only by the state change.

Decomposition:
- Package adder_carry_seq_pkg holds:
  - the state enum (IDLE=2'd0, RUN=2'd1, DONE=2'd2);
  - the localparam OP_ADD=1'b0, OP_SUB=1'b1.
- One sub-module is natural: adder_carry_pg_enc (combinational a, b, cin_reg -> p, g, cin). It keeps the P/G encoding identical to the slice definition and is reusable by wider sequencers.
- The bench instantiates the real adder_carry slice (or a behavioural model) on the slice_* ports.

Test Plan:
- WIDTH=8, A=8'h35, B=8'h4A, add, res_ready=1 -> res_sum=8'h7F, cout=0, ovf=0; res_valid rises 8 cycles after acceptance and lasts 1 cycle.
- A=8'hFF, B=8'h01, add -> res_sum=8'h00, cout=1, ovf=0 (wrap-around).
- A=8'h7F, B=8'h01, add -> res_sum=8'h80, cout=0, ovf=1. Then A=8'h80, B=8'h01, sub -> res_sum=8'h7F, cout=1, ovf=1.
- A=8'h10, B=8'h20, sub, with res_ready held low for 5 cycles:
  - res_sum=8'hF0, cout=0, ovf=0, stable throughout the stall;
  - op_ready=0 for the whole operation, and a second op_valid is not accepted until after the res handshake.
- Reset pulse at RUN bit 3 of A=8'hAA+B=8'h55 -> immediate IDLE, all outputs at reset values, no res_valid. The next op, 8'h01+8'h01, returns 8'h02.
- Back-to-back: 16 random add/sub ops with op_valid held and res_ready=1 -> every result matches the reference model, with exactly WIDTH+2 cycles between acceptances.

Source files
------------

// File: rtl/adder_carry_seq_pkg.sv
// Shared types for the bit-serial carry-slice sequencer: FSM state encoding and opcode values.
package adder_carry_seq_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } seq_state_t;

    localparam logic OP_ADD = 1'b0;
    localparam logic OP_SUB = 1'b1;

endpackage

// File: rtl/adder_carry_pg_enc.sv
// Propagate/generate encoder for one adder_carry slice (P = a^b, G = a, CI = carry register).
// Purely combinational, zero latency, no flow control.
module adder_carry_pg_enc
    import adder_carry_seq_pkg::*;
(
    input  logic i_a,
    input  logic i_b,
    input  logic i_cin_reg,
    output logic o_p,
    output logic o_g,
    output logic o_cin
);

    // With P = a^b, G = a is sufficient: when P = 0 the bits are equal, so a == a&b.
    assign o_p   = i_a ^ i_b;
    assign o_g   = i_a;
    assign o_cin = i_cin_reg;

endmodule

// File: rtl/adder_carry_serial_seq.sv
// Bit-serial add/sub over one external carry slice, LSB first; result valid WIDTH cycles after accept.
// op_ready only in IDLE; the result is held in DONE until res_ready, one op per WIDTH+2 cycles.
module adder_carry_serial_seq
    import adder_carry_seq_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             op_sub,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [WIDTH-1:0] res_sum,
    output logic             res_cout,
    output logic             res_ovf,
    output logic             slice_p,
    output logic             slice_g,
    output logic             slice_cin,
    input  logic             slice_sumout,
    input  logic             slice_cout
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    seq_state_t       r_state;
    seq_state_t       w_state_nxt;
    logic [WIDTH-1:0] r_sa;
    logic [WIDTH-1:0] r_sb;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic             r_cin_msb;
    logic [CNT_W-1:0] r_cnt;
    logic             w_run;
    logic             w_last;
    logic             w_accept;
    logic             w_p;
    logic             w_g;
    logic             w_cin;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        op_ready    = 1'b0;
        res_valid   = 1'b0;
        w_run       = 1'b0;
        case (r_state)
            IDLE: begin
                op_ready = 1'b1;
                if (op_valid) begin
                    w_state_nxt = RUN;
                end
            end
            RUN: begin
                w_run = 1'b1;
                if (w_last) begin
                    w_state_nxt = DONE;
                end
            end
            DONE: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    assign w_accept = op_ready && op_valid;
    assign w_last   = (r_cnt == CNT_W'(WIDTH - 1));

    // Subtract is A + ~B + 1: the +1 enters as the initial carry.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_sa      <= '0;
            r_sb      <= '0;
            r_res     <= '0;
            r_carry   <= 1'b0;
            r_cin_msb <= 1'b0;
            r_cnt     <= '0;
        end else if (w_accept) begin
            r_sa      <= op_a;
            r_sb      <= (op_sub == OP_ADD) ? op_b : ~op_b;
            r_res     <= '0;
            r_carry   <= (op_sub == OP_SUB);
            r_cin_msb <= 1'b0;
            r_cnt     <= '0;
        end else if (w_run) begin
            r_sa    <= {1'b0, r_sa[WIDTH-1:1]};
            r_sb    <= {1'b0, r_sb[WIDTH-1:1]};
            r_res   <= {slice_sumout, r_res[WIDTH-1:1]};
            r_carry <= slice_cout;
            r_cnt   <= r_cnt + CNT_W'(1);
            if (w_last) begin
                r_cin_msb <= r_carry;
            end
        end
    end

    adder_carry_pg_enc u_pg_enc (
        .i_a       (r_sa[0]),
        .i_b       (r_sb[0]),
        .i_cin_reg (r_carry),
        .o_p       (w_p),
        .o_g       (w_g),
        .o_cin     (w_cin)
    );

    assign slice_p   = w_run & w_p;
    assign slice_g   = w_run & w_g;
    assign slice_cin = w_run & w_cin;

    // Overflow: carry into the MSB differs from carry out of it.
    assign res_sum  = res_valid ? r_res : '0;
    assign res_cout = res_valid & r_carry;
    assign res_ovf  = res_valid & (r_carry ^ r_cin_msb);

endmodule

// File: tb/tb_adder_carry_serial_seq.sv
// Bench for adder_carry_serial_seq with a behavioural adder_carry slice on the slice_* ports.
module tb_adder_carry_serial_seq;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         reset;
    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_sub;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;
    logic         res_ovf;
    logic         slice_p;
    logic         slice_g;
    logic         slice_cin;
    logic         slice_sumout;
    logic         slice_cout;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    adder_carry_serial_seq #(.WIDTH(W)) dut (
        .clk          (clk),
        .reset        (reset),
        .op_valid     (op_valid),
        .op_ready     (op_ready),
        .op_a         (op_a),
        .op_b         (op_b),
        .op_sub       (op_sub),
        .res_valid    (res_valid),
        .res_ready    (res_ready),
        .res_sum      (res_sum),
        .res_cout     (res_cout),
        .res_ovf      (res_ovf),
        .slice_p      (slice_p),
        .slice_g      (slice_g),
        .slice_cin    (slice_cin),
        .slice_sumout (slice_sumout),
        .slice_cout   (slice_cout)
    );

    // Behavioural adder_carry slice
    assign slice_sumout = slice_p ^ slice_cin;
    assign slice_cout   = slice_p ? slice_cin : slice_g;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // Reference: plain integer arithmetic, returns {ovf, cout, sum}
    function automatic logic [W+1:0] model(input logic [W-1:0] a, input logic [W-1:0] b,
                                           input logic sub);
        int ua, ub, sa, sb, ur, sr;
        logic c, v;
        logic [W-1:0] s;
        ua = int'(a);
        ub = int'(b);
        sa = int'($signed(a));
        sb = int'($signed(b));
        if (sub) begin
            ur = ua - ub;
            sr = sa - sb;
            c  = (ua >= ub);
        end else begin
            ur = ua + ub;
            sr = sa + sb;
            c  = (ur >= (1 << W));
        end
        s = W'(ur);
        v = (sr > ((1 << (W - 1)) - 1)) || (sr < -(1 << (W - 1)));
        return {v, c, s};
    endfunction

    task automatic do_op(input logic [W-1:0] a, input logic [W-1:0] b, input logic sub,
                         input int stall, input bit keep_valid,
                         input logic [W-1:0] e_sum, input logic e_cout, input logic e_ovf,
                         input string tag);
        int wt;
        int lat;
        op_a      = a;
        op_b      = b;
        op_sub    = sub;
        op_valid  = 1'b1;
        res_ready = (stall == 0);
        wt = 0;
        while (!op_ready && wt < 50) begin
            @(posedge clk); #1;
            wt++;
        end
        chk({tag, "_accept_ready"}, 32'(op_ready), 32'd1);
        @(posedge clk); #1;
        if (keep_valid) begin
            op_a   = 8'hC3;
            op_b   = 8'h3C;
            op_sub = ~sub;
        end else begin
            op_valid = 1'b0;
        end
        lat = 0;
        while (!res_valid && lat < 50) begin
            chk({tag, "_busy_ready"}, 32'(op_ready), 32'd0);
            @(posedge clk); #1;
            lat++;
        end
        chk({tag, "_latency"}, 32'(lat), 32'(W));
        for (int s = 0; s < stall; s++) begin
            chk({tag, "_stall_valid"}, 32'(res_valid), 32'd1);
            chk({tag, "_stall_sum"}, 32'(res_sum), 32'(e_sum));
            chk({tag, "_stall_flags"}, 32'({res_cout, res_ovf}), 32'({e_cout, e_ovf}));
            chk({tag, "_stall_ready"}, 32'(op_ready), 32'd0);
            @(posedge clk); #1;
        end
        res_ready = 1'b1;
        chk({tag, "_sum"}, 32'(res_sum), 32'(e_sum));
        chk({tag, "_cout"}, 32'(res_cout), 32'(e_cout));
        chk({tag, "_ovf"}, 32'(res_ovf), 32'(e_ovf));
        @(posedge clk); #1;
        chk({tag, "_valid_drop"}, 32'(res_valid), 32'd0);
    endtask

    // Back-to-back monitor, sampled on the falling edge
    bit             mon_en = 1'b0;
    int             cyc = 0;
    int             last_acc;
    int             n_acc;
    logic [W+1:0]   exp_q[$];

    always @(negedge clk) begin
        logic [W+1:0] e;
        cyc++;
        if (mon_en) begin
            if (op_valid && op_ready) begin
                exp_q.push_back(model(op_a, op_b, op_sub));
                if (last_acc >= 0) begin
                    chk("b2b_interval", 32'(cyc - last_acc), 32'(W + 2));
                end
                last_acc = cyc;
                n_acc++;
            end
            if (res_valid && res_ready) begin
                chk("b2b_pending", 32'(exp_q.size() != 0), 32'd1);
                if (exp_q.size() != 0) begin
                    e = exp_q.pop_front();
                    chk("b2b_sum", 32'(res_sum), 32'(e[W-1:0]));
                    chk("b2b_cout", 32'(res_cout), 32'(e[W]));
                    chk("b2b_ovf", 32'(res_ovf), 32'(e[W+1]));
                end
            end
        end
    end

    typedef struct {
        logic [W-1:0] a;
        logic [W-1:0] b;
        logic         sub;
        int           stall;
        bit           keep;
        logic [W-1:0] e_sum;
        logic         e_cout;
        logic         e_ovf;
    } vec_t;

    vec_t tbl[6];

    initial begin
        int wt;
        bit seen;
        logic [W+1:0] m;

        tbl[0] = '{8'h35, 8'h4A, 1'b0, 0, 1'b0, 8'h7F, 1'b0, 1'b0};
        tbl[1] = '{8'hFF, 8'h01, 1'b0, 0, 1'b0, 8'h00, 1'b1, 1'b0};
        tbl[2] = '{8'h7F, 8'h01, 1'b0, 0, 1'b0, 8'h80, 1'b0, 1'b1};
        tbl[3] = '{8'h80, 8'h01, 1'b1, 0, 1'b0, 8'h7F, 1'b1, 1'b1};
        tbl[4] = '{8'h10, 8'h20, 1'b1, 5, 1'b1, 8'hF0, 1'b0, 1'b0};
        tbl[5] = '{8'h03, 8'h04, 1'b0, 0, 1'b0, 8'h07, 1'b0, 1'b0};

        reset     = 1'b1;
        op_valid  = 1'b0;
        op_a      = '0;
        op_b      = '0;
        op_sub    = 1'b0;
        res_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_op_ready", 32'(op_ready), 32'd1);
        chk("rst_res_valid", 32'(res_valid), 32'd0);
        chk("rst_res", 32'({res_sum, res_cout, res_ovf}), 32'd0);
        chk("rst_slice", 32'({slice_p, slice_g, slice_cin}), 32'd0);
        reset = 1'b0;
        @(posedge clk); #1;

        for (int i = 0; i < 6; i++) begin
            do_op(tbl[i].a, tbl[i].b, tbl[i].sub, tbl[i].stall, tbl[i].keep,
                  tbl[i].e_sum, tbl[i].e_cout, tbl[i].e_ovf, $sformatf("tbl%0d", i));
        end

        // Abandon AA+55 at bit 3 with an asynchronous reset
        op_a     = 8'hAA;
        op_b     = 8'h55;
        op_sub   = 1'b0;
        op_valid = 1'b1;
        @(posedge clk); #1;
        op_valid = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        chk("mid_run_slice_p", 32'(slice_p), 32'd1);
        reset = 1'b1;
        #1;
        chk("mid_rst_op_ready", 32'(op_ready), 32'd1);
        chk("mid_rst_res_valid", 32'(res_valid), 32'd0);
        chk("mid_rst_res", 32'({res_sum, res_cout, res_ovf}), 32'd0);
        chk("mid_rst_slice", 32'({slice_p, slice_g, slice_cin}), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;
        seen = 1'b0;
        for (int c = 0; c < 15; c++) begin
            seen |= res_valid;
            @(posedge clk); #1;
        end
        chk("mid_rst_no_result", 32'(seen), 32'd0);
        do_op(8'h01, 8'h01, 1'b0, 0, 1'b0, 8'h02, 1'b0, 1'b0, "after_rst");

        // Random single ops with random stalls
        for (int i = 0; i < 8; i++) begin
            logic [W-1:0] ra;
            logic [W-1:0] rb;
            logic         rs;
            ra = W'($urandom);
            rb = W'($urandom);
            rs = 1'($urandom);
            m  = model(ra, rb, rs);
            do_op(ra, rb, rs, int'($urandom_range(0, 2)), 1'b0,
                  m[W-1:0], m[W], m[W+1], $sformatf("rnd%0d", i));
        end

        // Back-to-back random stream with op_valid held
        last_acc  = -1;
        n_acc     = 0;
        res_ready = 1'b1;
        mon_en    = 1'b1;
        op_valid  = 1'b1;
        for (int i = 0; i < 16; i++) begin
            op_a   = W'($urandom);
            op_b   = W'($urandom);
            op_sub = 1'($urandom);
            wt = 0;
            while (!op_ready && wt < 40) begin
                @(posedge clk); #1;
                wt++;
            end
            chk("b2b_ready", 32'(op_ready), 32'd1);
            @(posedge clk); #1;
        end
        op_valid = 1'b0;
        wt = 0;
        while (exp_q.size() != 0 && wt < 40) begin
            @(posedge clk); #1;
            wt++;
        end
        chk("b2b_drain", 32'(exp_q.size()), 32'd0);
        chk("b2b_count", 32'(n_acc), 32'd16);
        mon_en = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
